// File: rtl/fire7_expand1_fmap_buffer_if.sv
// Channel-serial pixel stream leaving the fire7 expand-1x1 feature-map buffer.
interface fire7_expand1_fmap_buffer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pix_out;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_last;

    modport master (output pix_out, output pix_valid, output pix_last, input pix_ready);
    modport slave  (input pix_out, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/fire7_expand1_fmap_buffer.sv
// Captures one WOUT x WOUT map of DSP_NO-wide pixel words, then replays it
// channel-serially (pixel-major) over a valid/ready stream, on demand and repeatably.
module fire7_expand1_fmap_buffer #(
    parameter int WOUT   = 16,
    parameter int DSP_NO = 192,
    parameter int WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fire7_expand1_sample,
    input  logic [WIDTH-1:0]      ofm [0:DSP_NO-1],
    output logic                  ram_feedback,
    input  logic                  rd_start,
    output logic                  buf_full,
    output logic                  overflow,
    fire7_expand1_fmap_buffer_if.master pix_if
);
    localparam int NPIX = WOUT * WOUT;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(DSP_NO);
    localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(DSP_NO - 1);

    typedef logic [DSP_NO-1:0][WIDTH-1:0] word_t;

    // IDLE/FILL accept samples; FULL/DONE wait for rd_start; RD_ADDR/RD_LATCH fetch one pixel word
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_FULL, S_RD_ADDR, S_RD_LATCH, S_STREAM, S_DONE
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_pix_q;
    logic [CW-1:0]     rd_ch_q;
    logic [CW-1:0]     rd_ch_inc;
    logic              ram_feedback_q;
    logic              pix_valid_q;
    logic              pix_last_q;
    logic              buf_full_q;
    logic              overflow_q;
    logic [WIDTH-1:0]  pix_out_q;
    word_t             row_q;
    word_t             rd_word_q;
    word_t             wr_word;
    word_t             mem_q [NPIX];
    logic              wr_en;

    for (genvar c = 0; c < DSP_NO; c++) begin : g_pack
        assign wr_word[c] = ofm[c];
    end

    assign wr_en     = fire7_expand1_sample && (state_q == S_IDLE || state_q == S_FILL);
    assign rd_ch_inc = rd_ch_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
        rd_word_q <= mem_q[rd_pix_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_pix_q       <= '0;
            rd_ch_q        <= '0;
            ram_feedback_q <= 1'b0;
            pix_valid_q    <= 1'b0;
            pix_last_q     <= 1'b0;
            buf_full_q     <= 1'b0;
            overflow_q     <= 1'b0;
            pix_out_q      <= '0;
        end else begin
            ram_feedback_q <= 1'b0;
            if (fire7_expand1_sample && !wr_en) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_FILL: begin
                    if (fire7_expand1_sample) begin
                        if (wr_ptr_q == PIX_LAST) begin
                            state_q        <= S_FULL;
                            ram_feedback_q <= 1'b1;
                            buf_full_q     <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + AW'(1);
                            state_q  <= S_FILL;
                        end
                    end
                end
                S_FULL, S_DONE: begin
                    if (rd_start) begin
                        rd_pix_q <= '0;
                        rd_ch_q  <= '0;
                        state_q  <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: state_q <= S_RD_LATCH;
                S_RD_LATCH: begin
                    row_q       <= rd_word_q;
                    pix_out_q   <= rd_word_q[0];
                    pix_valid_q <= 1'b1;
                    pix_last_q  <= (rd_pix_q == PIX_LAST) && (DSP_NO == 1);
                    state_q     <= S_STREAM;
                end
                S_STREAM: begin
                    // pix_valid_q is always high here, so pix_ready alone completes a beat
                    if (pix_if.pix_ready) begin
                        if (rd_ch_q != CH_LAST) begin
                            rd_ch_q    <= rd_ch_inc;
                            pix_out_q  <= row_q[rd_ch_inc];
                            pix_last_q <= (rd_pix_q == PIX_LAST) && (rd_ch_inc == CH_LAST);
                        end else begin
                            rd_ch_q     <= '0;
                            pix_valid_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            if (rd_pix_q != PIX_LAST) begin
                                rd_pix_q <= rd_pix_q + AW'(1);
                                state_q  <= S_RD_ADDR;
                            end else begin
                                state_q  <= S_DONE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_feedback     = ram_feedback_q;
    assign buf_full         = buf_full_q;
    assign overflow         = overflow_q;
    assign pix_if.pix_out   = pix_out_q;
    assign pix_if.pix_valid = pix_valid_q;
    assign pix_if.pix_last  = pix_last_q;
endmodule

// File: doc/fire7_expand1_fmap_buffer.md
Name: fire7_expand1_fmap_buffer

Overview:
- Downstream neighbour of the fire7 expand-1x1 MAC stage. That stage presents all DSP_NO channels of one output pixel in parallel, qualified by a one-cycle sample strobe.
- This block captures the full WOUT×WOUT feature map into on-chip RAM, one DSP_NO-wide word per pixel.
- When the map is complete it signals ram_feedback upstream.
- On request it replays the map to the next layer as a channel-serial, pixel-major stream with valid/ready handshake.

Parameters:
- WOUT, 16, output feature-map side; map holds WOUT**2 pixels.
- DSP_NO, 192, channels per pixel (width of upstream ofm vector).
- WIDTH, 16, bits per channel value.
- AW, $clog2(WOUT**2), pixel address width (derived).
- CW, $clog2(DSP_NO), channel index width (derived).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- fire7_expand1_sample, input, 1, one-cycle strobe: ofm holds a valid pixel vector this cycle.
- ofm, input, WIDTH × [0:DSP_NO-1] unpacked, channel vector for current pixel.
- ram_feedback, output, 1, one-cycle pulse when pixel WOUT**2-1 has been written.
- rd_start, input, 1, request a full readout of the stored map.
- pix_out, output, WIDTH, streamed channel value.
- pix_valid, output, 1, pix_out valid.
- pix_ready, input, 1, consumer accepts pix_out when high together with pix_valid.
- pix_last, output, 1, high with the final beat (pixel WOUT**2-1, channel DSP_NO-1).
- buf_full, output, 1, high from the FULL state onward until reset.
- overflow, output, 1, sticky error flag.

Behaviour:
- Reset (sync, rst=1): state=IDLE; wr_ptr=0, rd_pix=0, rd_ch=0; ram_feedback=0, pix_valid=0, pix_last=0, buf_full=0, overflow=0, pix_out=0. RAM contents are not cleared. Reset mid-fill or mid-stream aborts immediately: pix_valid=0 in the cycle after rst is sampled.
- Storage: WOUT**2 words × (DSP_NO×WIDTH) bits; synchronous write; synchronous read with 1-cycle latency.
- States:
  - IDLE: first sample writes mem[0], wr_ptr←1, go FILL.
  - FILL: each sample writes mem[wr_ptr], wr_ptr++. The sample that writes address WOUT**2-1 moves to FULL and raises ram_feedback in the next cycle only (exactly one cycle high).
  - FULL: buf_full=1. rd_start → RD_ADDR with rd_pix=0, rd_ch=0.
  - RD_ADDR: drive read address rd_pix (1 cycle) → RD_LATCH.
  - RD_LATCH: RAM word registered into row_reg (1 cycle) → STREAM.
  - STREAM: pix_valid=1, pix_out=row_reg[rd_ch] (registered mux, stable while stalled). On pix_valid&&pix_ready:
    - if rd_ch<DSP_NO-1: rd_ch++.
    - else rd_ch←0; if rd_pix<WOUT**2-1: rd_pix++ → RD_ADDR; else → DONE.
  - DONE: buf_full=1, pix_valid=0. rd_start → RD_ADDR with rd_pix=0, rd_ch=0 (replay allowed).
- Timing: first beat valid on cycle rd_start+3 (counting rd_start cycle as 0). Between the last beat of pixel p and the first beat of p+1 there are exactly 2 cycles with pix_valid=0.
- pix_last = pix_valid && rd_pix==WOUT**2-1 && rd_ch==DSP_NO-1.
- Backpressure: pix_valid held high and pix_out held stable while pix_ready=0. No beat is dropped or duplicated.
- Samples arriving in FULL, RD_*, STREAM or DONE: not written; overflow←1 (sticky until rst). rd_start in IDLE/FILL/RD_*/STREAM: ignored.
- Simultaneous sample and rd_start in FULL: sample flags overflow, rd_start honoured.
- Pointers never wrap. The wr_ptr terminal count is WOUT**2-1. No arithmetic on data; values pass through bit-exact.

Test Plan:
- Fill: 256 samples spaced 3 cycles apart, ofm[c]={p[7:0],c[7:0]} → ram_feedback high exactly 1 cycle, the cycle after the 256th sample; buf_full=1; overflow=0.
- Stream, pix_ready=1: rd_start at cycle 0 → first beat 0x0000 at cycle 3; beat for pixel 0 channel 191 is 0x00BF; next beat 0x0100 after 2 invalid cycles; pix_last only on 0xFFBF; total 49152 beats, then DONE.
- Backpressure: pix_ready randomly low about 50% → identical beat sequence to the previous case; pix_out stable and pix_valid held during every stall.
- Overflow: extra sample after fill, and a sample during STREAM → overflow=1, stream data unchanged, no ram_feedback.
- Reset mid-stream at beat 1000 → next cycle pix_valid=0, state IDLE, buf_full=0. A fresh 256-sample fill then reproduces the first scenario's response.
- Replay: rd_start in DONE → second full stream identical to the first; rd_start asserted during STREAM is ignored.
